// File: rtl/seg7_to_hex_decoder.sv
// Receive side of the 7-segment digit link: samples an active-low segment bus,
// filters it for stability and hands each newly accepted hex digit over valid/ready.
module seg7_to_hex_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [0:6]       seg,
  output logic [3:0]       digit,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             bad_pattern,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [0:6]     BLANK   = 7'b1111111;

  localparam logic [0:0] TRACK = 1'b0;
  localparam logic [0:0] WAIT  = 1'b1;

  logic [0:0]    state;
  logic [0:6]    seg_q;
  logic [0:6]    last_acc;
  logic [CW-1:0] stab_cnt;

  logic [3:0] dec_val;
  logic       dec_legal;
  logic       dec_blank;

  // Exact inverse of the encoder glyph table; anything else is illegal.
  always_comb begin
    dec_val   = '0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (seg_q)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      BLANK: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= TRACK;
      seg_q       <= BLANK;
      last_acc    <= BLANK;
      stab_cnt    <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      bad_pattern <= 1'b0;
      err_count   <= '0;
    end else begin
      bad_pattern <= 1'b0;
      case (state)
        TRACK: begin
          if (seg != seg_q) begin
            seg_q    <= seg;
            stab_cnt <= CW'(1);
          end else if (stab_cnt != CNT_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
            // Accept only on the edge the window completes, and only for a new pattern.
            if (stab_cnt == CNT_MAX - 1'b1 && seg_q != last_acc) begin
              last_acc <= seg_q;
              if (dec_legal) begin
                digit       <= dec_val;
                digit_valid <= 1'b1;
                state       <= WAIT;
              end else if (!dec_blank) begin
                bad_pattern <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
              end
            end
          end
        end
        WAIT: begin
          if (digit_ready) begin
            digit_valid <= 1'b0;
            stab_cnt    <= '0;
            seg_q       <= seg;
            state       <= TRACK;
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_to_hex_decoder.sv
// Directed test of seg7_to_hex_decoder with STABLE_CYCLES=4, ERR_W=8.
module tb_seg7_to_hex_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic [0:6] seg;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_ready;
  logic       bad_pattern;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  int emits;
  int bads;
  logic [3:0] last_digit;

  localparam logic [0:6] P2  = 7'b0010010;
  localparam logic [0:6] P3  = 7'b0000110;
  localparam logic [0:6] P5  = 7'b0100100;
  localparam logic [0:6] P7  = 7'b0001111;
  localparam logic [0:6] P9  = 7'b0000100;
  localparam logic [0:6] PA  = 7'b0001000;
  localparam logic [0:6] PBL = 7'b1111111;
  localparam logic [0:6] PIL = 7'b1111110;

  seg7_to_hex_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .resetn(resetn), .seg(seg), .digit(digit),
    .digit_valid(digit_valid), .digit_ready(digit_ready),
    .bad_pattern(bad_pattern), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a pattern for n edges, tallying valid and bad_pattern cycles.
  task automatic run(input logic [0:6] p, input int n);
    seg = p;
    repeat (n) begin
      step();
      if (digit_valid === 1'b1) begin
        emits++;
        last_digit = digit;
      end
      if (bad_pattern === 1'b1) bads++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; seg = PBL; digit_ready = 1'b0;
    step(); step();
    vectors++;
    if ({digit, digit_valid, bad_pattern, err_count} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset: digit=%h valid=%b bad=%b err=%0d, want all zero",
               digit, digit_valid, bad_pattern, err_count);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int vcount = 0;
    seg = P2; digit_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (digit_valid) vcount++;
      vectors++;
      if (digit_valid !== (k == 4)) begin
        miscompares++;
        $display("FAIL basic_valid edge %0d: valid=%b want %b", k, digit_valid, k == 4);
      end
      if (k == 4) begin
        vectors++;
        if (digit !== 4'h2) begin
          miscompares++;
          $display("FAIL basic_digit: got %h want 2", digit);
        end
      end
    end
    vectors++;
    if (vcount != 1) begin
      miscompares++;
      $display("FAIL basic_once: %0d valid cycles, want 1", vcount);
    end
  endtask

  task automatic test_glitch();
    emits = 0;
    run(P3, 3);
    vectors++;
    if (emits != 0) begin
      miscompares++;
      $display("FAIL glitch_no3: %0d emits, want 0", emits);
    end
    seg = P5;
    for (int k = 1; k <= 6; k++) begin
      step();
      vectors++;
      if (digit_valid !== (k == 4) || (k == 4 && digit !== 4'h5)) begin
        miscompares++;
        $display("FAIL glitch_5 edge %0d: valid=%b digit=%h want valid=%b digit=5",
                 k, digit_valid, digit, k == 4);
      end
    end
  endtask

  task automatic test_rearm();
    emits = 0;
    run(P7, 6); run(PBL, 4); run(P7, 6);
    vectors++;
    if (emits != 2 || last_digit !== 4'h7) begin
      miscompares++;
      $display("FAIL rearm_blank: emits=%0d last=%h want 2 of 7", emits, last_digit);
    end
    run(P5, 6);
    emits = 0;
    run(P7, 6); run(P7, 6);
    vectors++;
    if (emits != 1) begin
      miscompares++;
      $display("FAIL rearm_noblank: emits=%0d want 1", emits);
    end
  endtask

  task automatic test_illegal();
    bads = 0; emits = 0;
    run(PIL, 6);
    vectors++;
    if (bads != 1 || err_count !== 8'd1 || emits != 0) begin
      miscompares++;
      $display("FAIL illegal_single: pulses=%0d err=%0d emits=%0d want 1,1,0",
               bads, err_count, emits);
    end
    for (int i = 0; i < 100; i++) begin run(PBL, 4); run(PIL, 4); end
    vectors++;
    if (err_count !== 8'd101) begin
      miscompares++;
      $display("FAIL illegal_count: err=%0d want 101", err_count);
    end
    for (int i = 0; i < 200; i++) begin run(PBL, 4); run(PIL, 4); end
    vectors++;
    if (err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL illegal_saturate: err=%0d want 255", err_count);
    end
    run(PBL, 4);
  endtask

  task automatic test_backpressure();
    digit_ready = 1'b0;
    run(P9, 5);
    vectors++;
    if (digit_valid !== 1'b1 || digit !== 4'h9) begin
      miscompares++;
      $display("FAIL bp_valid9: valid=%b digit=%h want 1/9", digit_valid, digit);
    end
    seg = PA; bads = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bad_pattern) bads++;
      vectors++;
      if (digit_valid !== 1'b1 || digit !== 4'h9) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: valid=%b digit=%h want 1/9", k, digit_valid, digit);
      end
    end
    digit_ready = 1'b1;
    step();
    vectors++;
    if (digit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_transfer: valid=%b want 0", digit_valid);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (digit_valid !== (k == 4) || (k == 4 && digit !== 4'hA)) begin
        miscompares++;
        $display("FAIL bp_next edge %0d: valid=%b digit=%h want valid=%b digit=A",
                 k, digit_valid, digit, k == 4);
      end
    end
    step();
  endtask

  task automatic test_reset_midhandshake();
    digit_ready = 1'b0;
    run(P3, 5);
    vectors++;
    if (digit_valid !== 1'b1 || digit !== 4'h3) begin
      miscompares++;
      $display("FAIL rst_pre: valid=%b digit=%h want 1/3", digit_valid, digit);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    vectors++;
    if ({digit, digit_valid, bad_pattern, err_count} !== 14'd0) begin
      miscompares++;
      $display("FAIL rst_mid: digit=%h valid=%b bad=%b err=%0d want all zero",
               digit, digit_valid, bad_pattern, err_count);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      vectors++;
      if (digit_valid !== (k >= 4) || (k >= 4 && digit !== 4'h3)) begin
        miscompares++;
        $display("FAIL rst_reemit edge %0d: valid=%b digit=%h want valid=%b digit=3",
                 k, digit_valid, digit, k >= 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_rearm();
    test_illegal();
    test_backpressure();
    test_reset_midhandshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
